// File: rtl/ascon_round_ctrl_pkg.sv
// Shared types and constants for the ASCON round sequencer.
// Macro ASCON_ABORT_EN (see ascon_round_ctrl) does not affect this package.
package ascon_round_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } round_fsm_t;

    localparam logic [3:0] ROUND_LAST = 4'd11;
    localparam int         NB_PA      = 12;
    localparam int         NB_PB      = 8;

    // Index of the first round constant for a permutation of nb_rounds rounds.
    function automatic int first_index(input int nb_rounds);
        return 32'sd12 - nb_rounds;
    endfunction

endpackage

// File: rtl/ascon_round_ctrl_round_counter.sv
// Loadable round-index up-counter; saturates at ROUND_LAST and flags it on last_o.
module ascon_round_counter
    import ascon_round_ctrl_pkg::*;
#(
    parameter int ROUND_W = 4
) (
    input  logic               clock_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [ROUND_W-1:0] load_val_i,
    input  logic               en_i,
    output logic [ROUND_W-1:0] round_o,
    output logic               last_o
);

    localparam logic [ROUND_W-1:0] LAST_VAL = ROUND_W'(ROUND_LAST);
    localparam logic [ROUND_W-1:0] ONE      = {{(ROUND_W-1){1'b0}}, 1'b1};

    logic [ROUND_W-1:0] round_r;

    // Round index register: load has priority, increment stops at the last round.
    always_ff @(posedge clock_i or negedge rst_i) begin
        if (!rst_i) begin
            round_r <= '0;
        end else if (load_i) begin
            round_r <= load_val_i;
        end else if (en_i && (round_r != LAST_VAL)) begin
            round_r <= round_r + ONE;
        end else begin
            round_r <= round_r;
        end
    end

    assign round_o = round_r;
    assign last_o  = (round_r == LAST_VAL);

endmodule

// File: rtl/ascon_round_ctrl.sv
// Round sequencer driving the ASCON permutation's round index and load/enable controls.
// Optional macro ASCON_ABORT_EN adds abort_i to cancel a run in progress.
module ascon_round_ctrl
    import ascon_round_ctrl_pkg::*;
#(
    parameter int ROUND_W = 4,
    parameter int NB_PA   = ascon_round_ctrl_pkg::NB_PA,
    parameter int NB_PB   = ascon_round_ctrl_pkg::NB_PB
) (
    input  logic               clock_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               pb_sel_i,
    output logic               init_state_o,
    output logic [ROUND_W-1:0] round_o,
    output logic               en_perm_o,
    output logic               busy_o,
    output logic               done_o
`ifdef ASCON_ABORT_EN
    ,
    input  logic               abort_i
`endif
);

    localparam logic [ROUND_W-1:0] FIRST_PA = ROUND_W'(first_index(NB_PA));
    localparam logic [ROUND_W-1:0] FIRST_PB = ROUND_W'(first_index(NB_PB));

    round_fsm_t         state_r;
    round_fsm_t         state_nxt_s;
    logic               load_s;
    logic [ROUND_W-1:0] load_val_s;
    logic               en_cnt_s;
    logic               last_s;
    logic               abort_s;
    logic               init_r;
    logic               en_perm_r;
    logic               busy_r;
    logic               done_r;

`ifdef ASCON_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    ascon_round_counter #(
        .ROUND_W    (ROUND_W)
    ) u_round_counter (
        .clock_i    (clock_i),
        .rst_i      (rst_i),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .en_i       (en_cnt_s),
        .round_o    (round_o),
        .last_o     (last_s)
    );

    // Next-state and counter control; every exit to IDLE/DONE parks the index at 0.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        load_val_s  = '0;
        en_cnt_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    state_nxt_s = INIT;
                    load_s      = 1'b1;
                    load_val_s  = pb_sel_i ? FIRST_PB : FIRST_PA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            INIT, RUN: begin
                if (abort_s) begin
                    state_nxt_s = IDLE;
                    load_s      = 1'b1;
                end else if (last_s) begin
                    state_nxt_s = DONE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                    en_cnt_s    = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                load_s      = 1'b1;
            end
        endcase
    end

    // State register plus outputs registered from the next state so they align with round_o.
    always_ff @(posedge clock_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= IDLE;
            init_r    <= 1'b0;
            en_perm_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            init_r    <= (state_nxt_s == INIT);
            en_perm_r <= (state_nxt_s == INIT) || (state_nxt_s == RUN);
            busy_r    <= (state_nxt_s == INIT) || (state_nxt_s == RUN);
            done_r    <= (state_nxt_s == DONE);
        end
    end

    assign init_state_o = init_r;
    assign en_perm_o    = en_perm_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Directed bench for ascon_round_ctrl with a behavioural ASCON permutation on its outputs.
module tb_ascon_round_ctrl;

    logic       clock_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       pb_sel_i;
    logic       init_state_o;
    logic [3:0] round_o;
    logic       en_perm_o;
    logic       busy_o;
    logic       done_o;
`ifdef ASCON_ABORT_EN
    logic       abort_i;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [319:0] S_I = {64'h00001000808C0001, 64'h6CB10AD9CA912F80,
                                    64'h691AED630E81901F, 64'h0C4C36A20853217C,
                                    64'h46487B3E06D9D7A8};

    logic [319:0] perm_r;
    logic [319:0] ref_s;

    always #5 clock_i = ~clock_i;

    ascon_round_ctrl dut (
        .clock_i      (clock_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pb_sel_i     (pb_sel_i),
        .init_state_o (init_state_o),
        .round_o      (round_o),
        .en_perm_o    (en_perm_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef ASCON_ABORT_EN
        ,
        .abort_i      (abort_i)
`endif
    );

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One ASCON round: constant addition, 5-bit S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  c;
        {x0, x1, x2, x3, x4} = s;
        c  = {4'hF - r, r};
        x2 = x2 ^ {56'h0, c};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Permutation datapath steered only by the sequencer's outputs.
    always @(posedge clock_i) begin
        if (en_perm_o) perm_r <= ascon_round(init_state_o ? S_I : perm_r, round_o);
    end

    function automatic logic [7:0] ctl(input logic init, input logic [3:0] rnd,
                                       input logic en, input logic busy, input logic done);
        return {init, rnd, en, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] exp);
        chk(tag, {56'h0, init_state_o, round_o, en_perm_o, busy_o, done_o}, {56'h0, exp});
    endtask

    initial begin
        rst_i    = 1'b0;
        start_i  = 1'b1;
        pb_sel_i = 1'b0;
`ifdef ASCON_ABORT_EN
        abort_i  = 1'b0;
`endif
        // Reset held with start asserted: everything stays quiet.
        repeat (3) begin
            @(negedge clock_i);
            chk_out("reset_hold", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        end
        start_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clock_i);
        chk_out("idle_after_reset", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));

        // p^a run with a start pulse at round 5 and a pb_sel change mid-run.
        start_i  = 1'b1;
        pb_sel_i = 1'b0;
        @(negedge clock_i);
        chk_out("pa_init", ctl(1'b1, 4'd0, 1'b1, 1'b1, 1'b0));
        start_i = 1'b0;
        for (int r = 1; r <= 11; r++) begin
            @(negedge clock_i);
            chk_out($sformatf("pa_round%0d", r), ctl(1'b0, 4'(r), 1'b1, 1'b1, 1'b0));
            start_i  = (r == 5);
            pb_sel_i = (r >= 3);
        end
        @(negedge clock_i);
        chk_out("pa_done", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clock_i);
        chk_out("pa_idle", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));

        ref_s = S_I;
        for (int r = 0; r < 12; r++) ref_s = ascon_round(ref_s, 4'(r));
        chk("perm_x0", perm_r[319:256], ref_s[319:256]);
        chk("perm_x1", perm_r[255:192], ref_s[255:192]);
        chk("perm_x2", perm_r[191:128], ref_s[191:128]);
        chk("perm_x3", perm_r[127:64],  ref_s[127:64]);
        chk("perm_x4", perm_r[63:0],    ref_s[63:0]);

        // p^b run: indices 4..11, pb_sel dropped after acceptance.
        start_i  = 1'b1;
        pb_sel_i = 1'b1;
        @(negedge clock_i);
        chk_out("pb_init", ctl(1'b1, 4'd4, 1'b1, 1'b1, 1'b0));
        start_i  = 1'b0;
        pb_sel_i = 1'b0;
        for (int r = 5; r <= 11; r++) begin
            @(negedge clock_i);
            chk_out($sformatf("pb_round%0d", r), ctl(1'b0, 4'(r), 1'b1, 1'b1, 1'b0));
        end
        @(negedge clock_i);
        chk_out("pb_done", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        @(negedge clock_i);
        chk_out("pb_idle", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));

        // Back-to-back p^a runs with start held high through DONE.
        start_i = 1'b1;
        for (int run = 0; run < 2; run++) begin
            @(negedge clock_i);
            chk_out($sformatf("b2b%0d_init", run), ctl(1'b1, 4'd0, 1'b1, 1'b1, 1'b0));
            start_i = (run == 0);
            for (int r = 1; r <= 11; r++) begin
                @(negedge clock_i);
                chk_out($sformatf("b2b%0d_round%0d", run, r), ctl(1'b0, 4'(r), 1'b1, 1'b1, 1'b0));
            end
            @(negedge clock_i);
            chk_out($sformatf("b2b%0d_done", run), ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        end
        @(negedge clock_i);
        chk_out("b2b_idle", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));

        // Reset asserted at round 7: immediate IDLE, no done pulse.
        start_i = 1'b1;
        @(negedge clock_i);
        chk_out("rst_run_init", ctl(1'b1, 4'd0, 1'b1, 1'b1, 1'b0));
        start_i = 1'b0;
        for (int r = 1; r <= 7; r++) @(negedge clock_i);
        chk_out("rst_run_round7", ctl(1'b0, 4'd7, 1'b1, 1'b1, 1'b0));
        rst_i = 1'b0;
        #1;
        chk_out("rst_run_async", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clock_i);
        chk_out("rst_run_nodone", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        rst_i = 1'b1;
        @(negedge clock_i);
        chk_out("rst_run_idle", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));

`ifdef ASCON_ABORT_EN
        // Abort at round 3, then a normal p^b run.
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        for (int r = 1; r <= 3; r++) @(negedge clock_i);
        chk_out("abort_round3", ctl(1'b0, 4'd3, 1'b1, 1'b1, 1'b0));
        abort_i = 1'b1;
        @(negedge clock_i);
        chk_out("abort_idle", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        abort_i = 1'b0;
        @(negedge clock_i);
        chk_out("abort_nodone", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        start_i  = 1'b1;
        pb_sel_i = 1'b1;
        @(negedge clock_i);
        chk_out("abort_rerun_init", ctl(1'b1, 4'd4, 1'b1, 1'b1, 1'b0));
        start_i = 1'b0;
        for (int r = 5; r <= 11; r++) @(negedge clock_i);
        chk_out("abort_rerun_last", ctl(1'b0, 4'd11, 1'b1, 1'b1, 1'b0));
        @(negedge clock_i);
        chk_out("abort_rerun_done", ctl(1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
